// File: rtl/inverse_key_schedule.sv
// AES-128 key expansion for the decrypt path. One round is expanded per cycle into an
// 11-entry store, and the entries are then served from round 10 down to round 0.
module inverse_key_schedule #(
    parameter int DATA_W = 128,
    parameter int NR     = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_valid_in,
    input  logic [DATA_W-1:0] key_in,
    output logic              key_ready,
    output logic              keys_loaded,
    input  logic              rk_req,
    output logic [DATA_W-1:0] round_key,
    output logic              rk_valid,
    output logic [3:0]        rk_round,
    output logic              rk_last
);
    localparam logic [3:0] NR_L = 4'(NR);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;
    state_t state_q, state_d;

    logic [DATA_W-1:0] rk_q [0:NR];
    logic [DATA_W-1:0] prev_q, next_key, round_key_q;
    logic [3:0]        cnt_q, ptr_q, rk_round_q;
    logic              rk_valid_q, rk_last_q;
    logic [7:0]        rcon;
    logic [31:0]       w0, w1, w2, w3, sub, n0, n1, n2, n3;
    logic              load_key, serve;

    // Table is stored byte 0x00 at the MSB end, hence the inverted index.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    always_comb begin
        case (cnt_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // prev_q always holds rk[cnt-1], so no read port on the store is needed to expand.
    always_comb begin
        {w0, w1, w2, w3} = prev_q;
        sub = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        n0  = w0 ^ sub ^ {rcon, 24'h0};
        n1  = w1 ^ n0;
        n2  = w2 ^ n1;
        n3  = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    assign load_key = key_valid_in && (state_q != EXPAND);
    assign serve    = rk_req && !key_valid_in && (state_q == READY);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (key_valid_in) state_d = EXPAND;
            EXPAND:  if (cnt_q == NR_L) state_d = READY;
            READY:   if (key_valid_in) state_d = EXPAND;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q       <= 4'd0;
            ptr_q       <= NR_L;
            prev_q      <= '0;
            round_key_q <= '0;
            rk_round_q  <= 4'd0;
            rk_valid_q  <= 1'b0;
            rk_last_q   <= 1'b0;
            for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
        end else begin
            rk_valid_q <= 1'b0;
            rk_last_q  <= 1'b0;
            if (load_key) begin
                rk_q[0] <= key_in;
                prev_q  <= key_in;
                cnt_q   <= 4'd1;
                ptr_q   <= NR_L;
            end else if (state_q == EXPAND) begin
                rk_q[cnt_q] <= next_key;
                prev_q      <= next_key;
                if (cnt_q == NR_L) begin
                    cnt_q <= 4'd0;
                    ptr_q <= NR_L;
                end else begin
                    cnt_q <= cnt_q + 4'd1;
                end
            end else if (serve) begin
                round_key_q <= rk_q[ptr_q];
                rk_round_q  <= ptr_q;
                rk_valid_q  <= 1'b1;
                rk_last_q   <= (ptr_q == 4'd0);
                ptr_q       <= (ptr_q == 4'd0) ? NR_L : ptr_q - 4'd1;
            end
        end
    end

    assign key_ready   = (state_q != EXPAND);
    assign keys_loaded = (state_q == READY);
    assign round_key   = round_key_q;
    assign rk_valid    = rk_valid_q;
    assign rk_round    = rk_round_q;
    assign rk_last     = rk_last_q;
endmodule
